// File: rtl/ne_window_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ne_window_ctrl_if
//  Description : Handshake/bus bundle between the NE window controller and its
//                environment (datapath, threshold source, feature consumer).
//                master : environment side (drives start/stop/samples/ready)
//                slave  : controller side (drives datapath controls/features)
//  Signals     : start, stop, sample_valid, ne_sum, threshold, feat_ready
//                (master -> slave); dp_en, dp_clr, win_done, feat_out,
//                feat_valid, detect, busy, overrun (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ne_window_ctrl_if #(
  parameter int OUT_W = 40
);
  logic                    start;
  logic                    stop;
  logic                    sample_valid;
  logic signed [OUT_W-1:0] ne_sum;
  logic signed [OUT_W-1:0] threshold;
  logic                    feat_ready;

  logic                    dp_en;
  logic                    dp_clr;
  logic                    win_done;
  logic signed [OUT_W-1:0] feat_out;
  logic                    feat_valid;
  logic                    detect;
  logic                    busy;
  logic                    overrun;

  modport master (
    output start, stop, sample_valid, ne_sum, threshold, feat_ready,
    input  dp_en, dp_clr, win_done, feat_out, feat_valid, detect, busy, overrun
  );

  modport slave (
    input  start, stop, sample_valid, ne_sum, threshold, feat_ready,
    output dp_en, dp_clr, win_done, feat_out, feat_valid, detect, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/ne_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ne_window_ctrl
//  Description : Window sequencer for a nonlinear-energy feature extractor.
//                Counts valid samples into windows of WIN_LEN, strobes
//                win_done at each boundary, and once NUM_WIN windows have
//                accumulated captures the datapath's summed value as a
//                feature every window. Captured features are compared against
//                a signed threshold; a crossing holds detect for HOLDOFF
//                windows.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous reset, active-low
//                bus    - ne_window_ctrl_if.slave (start/stop, sample_valid,
//                         ne_sum/threshold in; dp_en/dp_clr/win_done,
//                         feat_out/feat_valid/feat_ready handshake, detect,
//                         busy, overrun)
//  Revision    : 1.0 - initial release
// ============================================================================
module ne_window_ctrl #(
  parameter int WIN_LEN = 50,
  parameter int NUM_WIN = 5,
  parameter int OUT_W   = 40,
  parameter int HOLDOFF = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  ne_window_ctrl_if.slave  bus
);

  localparam int SAMP_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int WIN_W  = $clog2(NUM_WIN + 1);
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_CLR  = 2'd1;
  localparam logic [1:0] C_ACQ  = 2'd2;
  localparam logic [1:0] C_CAP  = 2'd3;

  logic [1:0]              state_q,    state_d;
  logic [SAMP_W-1:0]       samp_cnt_q, samp_cnt_d;
  logic [WIN_W-1:0]        win_cnt_q,  win_cnt_d;
  logic [HOLD_W-1:0]       holdoff_cnt_q, holdoff_cnt_d;
  logic signed [OUT_W-1:0] feat_out_q, feat_out_d;
  logic                    feat_valid_q, feat_valid_d;
  logic                    overrun_q,  overrun_d;

  logic w_dp_en;
  logic w_dp_clr;
  logic w_win_done;
  logic w_busy;
  logic w_samp_last;
  logic w_win_last;
  logic w_win_sat;
  logic w_stop;
  logic w_start;
  logic w_cap;

  assign w_samp_last = (samp_cnt_q == SAMP_W'(WIN_LEN - 1));
  // The boundary that completes window NUM_WIN (or any later one) triggers CAP
  assign w_win_last  = (win_cnt_q >= WIN_W'(NUM_WIN - 1));
  assign w_win_sat   = (win_cnt_q == WIN_W'(NUM_WIN));
  assign w_stop      = bus.stop && (state_q != C_IDLE);
  assign w_start     = (state_q == C_IDLE) && bus.start && !bus.stop;
  // A stop during CAP aborts the capture as well
  assign w_cap       = (state_q == C_CAP) && !bus.stop;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= C_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE: begin
        if (bus.start && !bus.stop) state_d = C_CLR;
      end
      C_CLR: begin
        state_d = bus.stop ? C_IDLE : C_ACQ;
      end
      C_ACQ: begin
        if (bus.stop) begin
          state_d = C_IDLE;
        end else if (w_win_done && w_win_last) begin
          state_d = C_CAP;
        end
      end
      C_CAP: begin
        state_d = bus.stop ? C_IDLE : C_ACQ;
      end
      default: state_d = C_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_dp_en    = 1'b1;
    w_dp_clr   = 1'b0;
    w_win_done = 1'b0;
    w_busy     = (state_q != C_IDLE);
    case (state_q)
      C_CLR: begin
        w_dp_clr = 1'b1;
      end
      C_ACQ: begin
        // Datapath enable is active-low and follows the sample strobe
        w_dp_en    = ~bus.sample_valid;
        w_win_done = bus.sample_valid && w_samp_last;
      end
      default: begin
        w_dp_en = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters, feature register and status flags: next state
  // --------------------------------------------------------------------------
  always_comb begin
    samp_cnt_d    = samp_cnt_q;
    win_cnt_d     = win_cnt_q;
    holdoff_cnt_d = holdoff_cnt_q;
    feat_out_d    = feat_out_q;
    feat_valid_d  = feat_valid_q;
    overrun_d     = overrun_q;

    if (w_start) begin
      overrun_d = 1'b0;
    end

    if (w_stop) begin
      // feat_out and overrun survive an abort so the last result stays readable
      samp_cnt_d    = '0;
      win_cnt_d     = '0;
      holdoff_cnt_d = '0;
      feat_valid_d  = 1'b0;
    end else begin
      if (state_q == C_CLR) begin
        samp_cnt_d = '0;
        win_cnt_d  = '0;
      end

      if ((state_q == C_ACQ) && bus.sample_valid) begin
        if (w_samp_last) begin
          samp_cnt_d = '0;
          if (!w_win_sat) win_cnt_d = win_cnt_q + WIN_W'(1);
        end else begin
          samp_cnt_d = samp_cnt_q + SAMP_W'(1);
        end
      end

      if (feat_valid_q && bus.feat_ready) begin
        feat_valid_d = 1'b0;
      end

      if (w_win_done && (holdoff_cnt_q != '0)) begin
        holdoff_cnt_d = holdoff_cnt_q - HOLD_W'(1);
      end

      // Capture overrides the handshake clear so a same-cycle accept+capture
      // leaves the new feature pending
      if (w_cap) begin
        feat_out_d   = bus.ne_sum;
        feat_valid_d = 1'b1;
        // Lost feature: unaccepted one overwritten, or a sample dropped in CAP
        if (bus.sample_valid || (feat_valid_q && !bus.feat_ready)) begin
          overrun_d = 1'b1;
        end
        if (bus.ne_sum > bus.threshold) begin
          holdoff_cnt_d = HOLD_W'(HOLDOFF);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt_q    <= '0;
      win_cnt_q     <= '0;
      holdoff_cnt_q <= '0;
      feat_out_q    <= '0;
      feat_valid_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      samp_cnt_q    <= samp_cnt_d;
      win_cnt_q     <= win_cnt_d;
      holdoff_cnt_q <= holdoff_cnt_d;
      feat_out_q    <= feat_out_d;
      feat_valid_q  <= feat_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.dp_en      = w_dp_en;
  assign bus.dp_clr     = w_dp_clr;
  assign bus.win_done   = w_win_done;
  assign bus.busy       = w_busy;
  assign bus.feat_out   = feat_out_q;
  assign bus.feat_valid = feat_valid_q;
  assign bus.detect     = (holdoff_cnt_q != '0);
  assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ne_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ne_window_ctrl
//  Description : Self-checking bench for ne_window_ctrl. A behavioural model
//                (sample/window arithmetic, feature slot, holdoff counter)
//                predicts every output each cycle; scenario tasks add
//                directed checks for window timing, overrun, detection,
//                gating, stop and reset behaviour, then a random soak.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ne_window_ctrl;

  localparam int WIN_LEN = 50;
  localparam int NUM_WIN = 5;
  localparam int OUT_W   = 40;
  localparam int HOLDOFF = 4;

  typedef logic [OUT_W+22:0] vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ne_window_ctrl_if #(.OUT_W(OUT_W)) bus ();

  ne_window_ctrl #(
    .WIN_LEN (WIN_LEN),
    .NUM_WIN (NUM_WIN),
    .OUT_W   (OUT_W),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural model ----------------
  bit     m_run;      // a run is active
  bit     m_clr;      // first cycle of a run (datapath clear)
  bit     m_cap;      // capture cycle pending
  longint m_samples;  // accepted samples since the run began
  int     m_hold;     // windows of detect remaining
  bit     m_fv;
  bit     m_ovr;
  longint m_fo;

  function automatic void model_reset();
    m_run = 0; m_clr = 0; m_cap = 0; m_samples = 0;
    m_hold = 0; m_fv = 0; m_ovr = 0; m_fo = 0;
  endfunction

  function automatic void model_update();
    bit     st  = bus.start;
    bit     sp  = bus.stop;
    bit     sv  = bus.sample_valid;
    bit     rdy = bus.feat_ready;
    longint ns  = longint'($signed(bus.ne_sum));
    longint th  = longint'($signed(bus.threshold));
    if (!m_run) begin
      if (st && !sp) begin m_run = 1; m_clr = 1; m_ovr = 0; end
    end else if (sp) begin
      m_run = 0; m_clr = 0; m_cap = 0; m_samples = 0; m_hold = 0; m_fv = 0;
    end else if (m_clr) begin
      m_clr = 0; m_samples = 0;
    end else if (m_cap) begin
      m_cap = 0;
      if (sv || (m_fv && !rdy)) m_ovr = 1;
      m_fv = 1;
      m_fo = ns;
      if (ns > th) m_hold = HOLDOFF;
    end else begin
      if (m_fv && rdy) m_fv = 0;
      if (sv) begin
        if (m_samples % WIN_LEN == WIN_LEN - 1) begin
          if (m_hold > 0) m_hold--;
          if ((m_samples + 1) / WIN_LEN >= NUM_WIN) m_cap = 1;
        end
        m_samples++;
      end
    end
  endfunction

  function automatic vec_t exp_vec();
    bit     act = m_run && !m_clr && !m_cap;
    bit     sv  = bus.sample_valid;
    longint w   = m_samples / WIN_LEN;
    if (w > NUM_WIN) w = NUM_WIN;
    return {m_run, !(act && sv), m_run && m_clr,
            act && sv && (m_samples % WIN_LEN == WIN_LEN - 1),
            m_fv, (m_hold > 0), m_ovr, OUT_W'(m_fo),
            8'(m_samples % WIN_LEN), 8'(w)};
  endfunction

  function automatic vec_t dut_vec();
    return {bus.busy, bus.dp_en, bus.dp_clr, bus.win_done, bus.feat_valid,
            bus.detect, bus.overrun, bus.feat_out,
            8'(dut.samp_cnt_q), 8'(dut.win_cnt_q)};
  endfunction

  // ---------------- drivers ----------------
  task automatic set_in(input bit st, input bit sp, input bit sv, input bit rdy);
    bus.start        = st;
    bus.stop         = sp;
    bus.sample_valid = sv;
    bus.feat_ready   = rdy;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input bit rdy);
    set_in(1, 0, 0, rdy);
    tick();
    set_in(0, 0, 0, rdy);
    tick();
  endtask

  task automatic do_stop(input bit rdy);
    set_in(0, 1, 0, rdy);
    tick();
    set_in(0, 0, 0, rdy);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    set_in(1, 0, 1, 1);
    bus.ne_sum    = OUT_W'(123);
    bus.threshold = OUT_W'(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d act=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    set_in(0, 0, 1, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_release cyc=%0d act=%h exp=%h", i, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_nominal();
    int wd_idx[$];
    int fv_rise = -1;
    int rises   = 0;
    int det_seen = 0;
    bit fv_prev = 0;
    bus.ne_sum    = OUT_W'(1000);
    bus.threshold = OUT_W'(2000);
    set_in(1, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0);
    #1;
    n_tests++;
    if (bus.dp_clr !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_clr dp_clr=%b busy=%b exp 1 1", bus.dp_clr, bus.busy);
    end
    tick();
    for (int cyc = 0; cyc < 256; cyc++) begin
      set_in(0, 0, cyc < 250, 0);
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL nominal cyc=%0d act=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (bus.win_done === 1'b1) wd_idx.push_back(cyc);
      if (bus.feat_valid === 1'b1 && !fv_prev) begin rises++; fv_rise = cyc; end
      fv_prev = (bus.feat_valid === 1'b1);
      if (bus.detect !== 1'b0) det_seen++;
      tick();
    end
    n_tests++;
    if (wd_idx.size() != 5) begin
      n_fail++;
      $display("FAIL nominal_wd_count act=%0d exp=5", wd_idx.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if (wd_idx[k] != 49 + 50 * k) begin
          n_fail++;
          $display("FAIL nominal_wd_idx k=%0d act=%0d exp=%0d", k, wd_idx[k], 49 + 50 * k);
        end
      end
    end
    // win_done cycle 249, capture in CAP (250), flag visible from 251
    n_tests++;
    if (rises != 1 || fv_rise != 251) begin
      n_fail++;
      $display("FAIL nominal_feat rises=%0d at=%0d exp 1 at 251", rises, fv_rise);
    end
    n_tests++;
    if (bus.feat_out !== OUT_W'(1000) || det_seen != 0) begin
      n_fail++;
      $display("FAIL nominal_value feat_out=%0d detect_cycles=%0d exp 1000 0",
               $signed(bus.feat_out), det_seen);
    end
    do_stop(0);
  endtask

  task automatic test_overrun();
    bit seen_fv = 0;
    bit dropped = 0;
    bus.ne_sum    = OUT_W'(1111);
    bus.threshold = OUT_W'(5000);
    do_start(0);
    for (int cyc = 0; cyc < 320 && !(m_samples >= 300 && !m_cap && m_fv && m_ovr); cyc++) begin
      set_in(0, 0, (m_samples < 300) && !m_cap, 0);
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL overrun cyc=%0d act=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (bus.feat_valid === 1'b1) begin
        seen_fv = 1;
        bus.ne_sum = OUT_W'(2222);
      end else if (seen_fv) begin
        dropped = 1;
      end
      tick();
    end
    set_in(0, 0, 0, 0);
    #1;
    n_tests++;
    if (bus.feat_out !== OUT_W'(2222) || bus.overrun !== 1'b1 ||
        bus.feat_valid !== 1'b1 || dropped) begin
      n_fail++;
      $display("FAIL overrun_final feat_out=%0d overrun=%b fv=%b dropped=%b exp 2222 1 1 0",
               $signed(bus.feat_out), bus.overrun, bus.feat_valid, dropped);
    end
    do_stop(1);
  endtask

  task automatic test_detect();
    bit captured = 0;
    int post_wd  = 0;
    int hi_wd    = 0;
    int det_cyc  = 0;
    bit fifth_lo = 0;
    bus.ne_sum    = OUT_W'(2001);
    bus.threshold = OUT_W'(2000);
    do_start(1);
    for (int cyc = 0; cyc < 560 && m_samples < 500; cyc++) begin
      set_in(0, 0, !m_cap, 1);
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL detect cyc=%0d act=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (bus.feat_valid === 1'b1) begin captured = 1; bus.ne_sum = OUT_W'(0); end
      if (captured && bus.win_done === 1'b1) begin
        post_wd++;
        if (bus.detect === 1'b1) hi_wd++;
        if (post_wd == HOLDOFF + 1) fifth_lo = (bus.detect === 1'b0);
      end
      tick();
    end
    n_tests++;
    if (hi_wd != HOLDOFF || !fifth_lo) begin
      n_fail++;
      $display("FAIL detect_holdoff strobes_high=%0d low_after=%b exp %0d 1", hi_wd, fifth_lo, HOLDOFF);
    end
    do_stop(1);
    bus.ne_sum = OUT_W'(2000);
    do_start(1);
    for (int cyc = 0; cyc < 320 && m_samples < 300; cyc++) begin
      set_in(0, 0, !m_cap, 1);
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL detect_eq cyc=%0d act=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (bus.detect !== 1'b0) det_cyc++;
      tick();
    end
    n_tests++;
    if (det_cyc != 0) begin
      n_fail++;
      $display("FAIL detect_equal detect_cycles=%0d exp 0", det_cyc);
    end
    do_stop(1);
  endtask

  task automatic test_gated();
    int first_wd = -1;
    bus.ne_sum = OUT_W'(7);
    do_start(1);
    for (int cyc = 0; cyc < 200; cyc++) begin
      set_in(0, 0, (cyc % 3) == 0, 1);
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL gated cyc=%0d act=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (bus.win_done === 1'b1 && first_wd < 0) first_wd = cyc;
      tick();
    end
    n_tests++;
    if (first_wd != 147) begin
      n_fail++;
      $display("FAIL gated_first_wd act=%0d exp=147", first_wd);
    end
    do_stop(1);
  endtask

  task automatic test_stop_boundary();
    bus.ne_sum = OUT_W'(3333);
    do_start(0);
    for (int cyc = 0; cyc < 249; cyc++) begin
      set_in(0, 0, 1, 0);
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stopb cyc=%0d act=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    set_in(0, 1, 1, 0);
    #1;
    n_tests++;
    if (bus.win_done !== 1'b1) begin
      n_fail++;
      $display("FAIL stopb_win_done act=%b exp=1", bus.win_done);
    end
    tick();
    set_in(0, 0, 0, 0);
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.feat_valid !== 1'b0 || dut.samp_cnt_q !== '0 ||
        dut.win_cnt_q !== '0 || dut.holdoff_cnt_q !== '0) begin
      n_fail++;
      $display("FAIL stopb_after busy=%b fv=%b samp=%0d win=%0d hold=%0d exp all 0",
               bus.busy, bus.feat_valid, dut.samp_cnt_q, dut.win_cnt_q, dut.holdoff_cnt_q);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stopb_idle cyc=%0d act=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_reset_midrun();
    bus.ne_sum = OUT_W'(5000);
    do_start(0);
    for (int cyc = 0; cyc < 23; cyc++) begin
      set_in(0, 0, 1, 0);
      tick();
    end
    set_in(0, 0, 1, 0);
    #1;
    n_tests++;
    if (dut_vec() !== exp_vec() || dut.samp_cnt_q !== 6'd23) begin
      n_fail++;
      $display("FAIL rstmid_pre act=%h exp=%h", dut_vec(), exp_vec());
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL rstmid_async act=%h exp=%h", dut_vec(), exp_vec());
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      set_in(0, 0, 1, 0);
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rstmid_idle cyc=%0d act=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    set_in(1, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0);
    #1;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_idle busy=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_random();
    longint th;
    longint ns;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      th = longint'($urandom_range(0, 200)) - 100;
      if ($urandom_range(0, 9) == 0) ns = longint'($urandom) - 64'sd2147483648;
      else ns = th + longint'($urandom_range(0, 4)) - 2;
      bus.threshold = OUT_W'(th);
      bus.ne_sum    = OUT_W'(ns);
      set_in($urandom_range(0, 9) == 0, $urandom_range(0, 799) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d act=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    set_in(0, 0, 0, 0);
    bus.ne_sum    = '0;
    bus.threshold = '0;
    test_reset();
    test_nominal();
    test_overrun();
    test_detect();
    test_gated();
    test_stop_boundary();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
